mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port memory (sp_ram req/gnt/rvalid protocol) between the zeroriscy instruction fetch port and its LSU data port. Round-robin arbitration, in-flight request tracking, and rvalid/rdata return-steering to the issuing requester. Lets a SoC run unified code/data from one RAM instance instead of separate inst_mem and data_mem.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; be width = DATA_WIDTH/8
MAX_OUTSTANDING, 2, max granted-but-not-returned transactions (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_rvalid_o  out  1  fetch read data valid
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_rdata_o  out  DATA_WIDTH  fetch read data
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU grant
data_rvalid_o  out  1  LSU response valid
data_we_i  in  1  LSU write enable
data_be_i  in  DATA_WIDTH/8  LSU byte enables
data_addr_i  in  ADDR_WIDTH  LSU address
data_wdata_i  in  DATA_WIDTH  LSU write data
data_rdata_o  out  DATA_WIDTH  LSU read data
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset: err_o=0, outstanding count=0, last_grant=INSTR, hold register invalid. Combinational outputs are therefore 0 while requests are 0.
- Selection (combinational):
  - If hold valid and the held requester still requests, select it.
  - Else if exactly one requester is active, select it.
  - Else if both are active, select the requester not in last_grant. The first tie after reset goes to DATA.
- mem_req_o = (instr_req_i | data_req_i) & (count < MAX_OUTSTANDING).
- mem_we_o/be/addr/wdata mux from the selected requester. For instr: we=0, be=all-ones, wdata=0.
- Grant: sel_gnt_o = mem_gnt_i & mem_req_o & selected. The unselected requester's gnt is 0. Grant is combinational, zero added latency.
- Hold: if mem_req_o & !mem_gnt_i, register hold=valid with the selected ID. The next cycle presents the same requester even if the other one wins RR. Hold clears on grant or when the held requester drops req.
- On a granted cycle: push the requester ID into the ID FIFO, count+1, last_grant=ID.
- On mem_rvalid_i:
  - Pop the FIFO head, count-1.
  - Assert the head requester's rvalid_o in the same cycle; the other rvalid_o stays 0.
  - instr_rdata_o and data_rdata_o both = mem_rdata_i; rvalid qualifies them.
- Same-cycle grant and rvalid: push and pop both occur, count unchanged, FIFO order preserved.
- Full (count==MAX_OUTSTANDING): mem_req_o=0 and both gnt=0, even if rvalid arrives that cycle. The request is re-presented the following cycle.
- mem_rvalid_i with empty FIFO: protocol error. No rvalid is forwarded, count stays 0, err_o set. err_o clears only on reset.
- Reset mid-operation: FIFO, count and hold flush immediately (asynchronous). rvalids arriving after release with an empty FIFO set err_o. The integrator must reset memory and core together.
- Requester IDs return in grant order. The memory is in-order by contract.

Decomposition:
- Package mem_arb_pkg: typedef enum logic {REQ_INSTR=1'b0, REQ_DATA=1'b1} req_id_e; ID width constant.
- Sub-module mem_arb_id_fifo: synchronous FIFO of req_id_e, depth MAX_OUTSTANDING, push/pop/full/empty/count, same clock and reset.
- The top holds the arbiter, the hold register and the muxes.

Test Plan:
- Instr-only fetches at 0x0, 0x4, 0x8 against sp_ram (gnt same cycle, rvalid +1) -> 3 instr_gnt_o, instr_rvalid_o one cycle after each; data_rvalid_o never asserts; mem_we_o=0, mem_be_o=4'hF.
- Both requesters asserted continuously from reset -> grants alternate DATA, INSTR, DATA, INSTR; each rvalid steers to the matching requester in order.
- Data store addr 0x40, be=4'b0011, wdata=0xDEADBEEF, mem_gnt_i held low 3 cycles while instr_req_i also rises -> mem_addr_o stays 0x40 with data fields stable until grant; instr granted only afterwards.
- MAX_OUTSTANDING=2, rvalid delayed 4 cycles -> two grants, then mem_req_o=0 until the first rvalid. No grant in the rvalid cycle; the grant comes the next cycle.
- Spurious mem_rvalid_i with no outstanding -> no rvalid_o, err_o=1 and stays 1 until rst_ni low.
- Assert rst_ni low with 2 outstanding -> count=0 and all gnt/rvalid/err 0 immediately. After release, the first tie is granted to DATA.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ID_WIDTH = 1;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions awaiting rvalid.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  req_id_e          push_id_i,
    input  logic             pop_i,
    output req_id_e          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ID_WIDTH-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign head_o  = req_id_e'(slots_q[rd_ptr_q]);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                slots_q[wr_ptr_q] <= push_id_i;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one sp_ram port between instruction fetch and LSU,
// with in-order rvalid/rdata steering back to the requester that was granted.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    req_id_e          sel;
    req_id_e          fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             any_req, held_req, grant, rsp_valid;

    logic    hold_valid_q, hold_valid_d;
    req_id_e hold_id_q, hold_id_d;
    req_id_e last_grant_q, last_grant_d;
    logic    err_q, err_d;

    always_comb begin
        any_req  = instr_req_i | data_req_i;
        held_req = (hold_id_q == REQ_DATA) ? data_req_i : instr_req_i;

        // A stalled request keeps the port until granted, so payload never changes mid-handshake.
        if (hold_valid_q && held_req) begin
            sel = hold_id_q;
        end else if (instr_req_i && data_req_i) begin
            sel = other_req(last_grant_q);
        end else if (data_req_i) begin
            sel = REQ_DATA;
        end else begin
            sel = REQ_INSTR;
        end

        mem_req_o   = any_req & ~fifo_full;
        grant       = mem_req_o & mem_gnt_i;
        instr_gnt_o = grant & (sel == REQ_INSTR);
        data_gnt_o  = grant & (sel == REQ_DATA);

        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_req) begin
            if (sel == REQ_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end

        rsp_valid      = mem_rvalid_i & ~fifo_empty;
        instr_rvalid_o = rsp_valid & (fifo_head == REQ_INSTR);
        data_rvalid_o  = rsp_valid & (fifo_head == REQ_DATA);

        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            hold_valid_d = 1'b0;
            last_grant_d = sel;
        end else if (mem_req_o) begin
            hold_valid_d = 1'b1;
            hold_id_d    = sel;
        end else if (hold_valid_q && !held_req) begin
            hold_valid_d = 1'b0;
        end

        err_d = err_q | (mem_rvalid_i & fifo_empty);
    end

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;
    assign err_o         = err_q;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (grant),
        .push_id_i (sel),
        .pop_i     (mem_rvalid_i),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_id_q    <= REQ_INSTR;
            last_grant_q <= REQ_INSTR;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // Grants are gated by fifo_full, so the tracked count can never exceed the limit.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with an sp_ram-style memory model.
module tb_mem_port_arbiter;

    localparam int unsigned MAXO = 2;

    typedef struct {int cyc; bit id; logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata;} gnt_t;
    typedef struct {int cyc; bit id; bit rd; logic [31:0] data;} rsp_t;
    typedef struct {int cyc; bit req; bit err;} cyc_t;
    typedef struct {bit id; bit rd; logic [31:0] data;} out_t;
    typedef struct {int rdy; logic [31:0] data;} env_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i = '0, instr_rdata_o;
    logic        data_req_i = 1'b0, data_gnt_o, data_rvalid_o, data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
    logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
    logic        err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    int n_cmp = 0, n_fail = 0, cyc = 0;

    logic [31:0] env_ram [32];
    logic [31:0] ref_ram [32];

    bit          i_pend, d_pend, d_we, gen_i, gen_d, spurious;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    int          req_pct = 100, gnt_pct = 100, lat_min = 1, lat_max = 1, last_rdy = 0;

    env_t env_q[$];
    out_t m_q[$];
    bit   m_hold_v, m_hold_id, m_last, m_err;
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    cyc_t cyc_q[$];
    gnt_t mg;
    rsp_t mr;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
        return old;
    endfunction

    // Reference: arbitration rules applied to the driven stimulus, outstanding work as a queue.
    task automatic model_step();
        bit   ir, dr, want, sel, issue;
        out_t o;
        ir    = i_pend;
        dr    = d_pend;
        issue = (ir || dr) && (m_q.size() < MAXO);
        want  = m_hold_id ? dr : ir;
        if (m_hold_v && want) sel = m_hold_id;
        else if (ir && dr)    sel = !m_last;
        else                  sel = dr;
        cyc_q.push_back('{cyc, issue, m_err});
        if (mem_rvalid_i) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                o = m_q.pop_front();
                rsp_q.push_back('{cyc, o.id, o.rd, o.data});
            end
        end
        if (issue && mem_gnt_i) begin
            if (sel) begin
                gnt_q.push_back('{cyc, 1'b1, d_addr, d_we, d_be, d_wdata});
                if (d_we) ref_ram[d_addr[6:2]] = merge(ref_ram[d_addr[6:2]], d_wdata, d_be);
                m_q.push_back('{1'b1, !d_we, ref_ram[d_addr[6:2]]});
            end else begin
                gnt_q.push_back('{cyc, 1'b0, i_addr, 1'b0, 4'hF, 32'h0});
                m_q.push_back('{1'b0, 1'b1, ref_ram[i_addr[6:2]]});
            end
            m_last   = sel;
            m_hold_v = 1'b0;
        end else if (issue) begin
            m_hold_v  = 1'b1;
            m_hold_id = sel;
        end else if (m_hold_v && !want) begin
            m_hold_v = 1'b0;
        end
    endtask

    task automatic cycle();
        int rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (!i_pend && gen_i && $urandom_range(99) < req_pct) begin
            i_pend = 1'b1;
            i_addr = 32'($urandom_range(31)) << 2;
        end
        if (!d_pend && gen_d && $urandom_range(99) < req_pct) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_be    = 4'($urandom_range(15, 1));
            d_addr  = 32'($urandom_range(31)) << 2;
            d_wdata = $urandom;
        end
        instr_req_i  = i_pend;
        instr_addr_i = i_addr;
        data_req_i   = d_pend;
        data_we_i    = d_we;
        data_be_i    = d_be;
        data_addr_i  = d_addr;
        data_wdata_i = d_wdata;
        mem_gnt_i    = ($urandom_range(99) < gnt_pct);
        mem_rdata_i  = $urandom;
        mem_rvalid_i = 1'b0;
        if (env_q.size() > 0 && env_q[0].rdy <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = env_q[0].data;
            void'(env_q.pop_front());
        end else if (spurious) begin
            mem_rvalid_i = 1'b1;
            spurious     = 1'b0;
        end
        model_step();
        #2;
        if (mem_req_o && mem_gnt_i) begin
            rdy = cyc + $urandom_range(lat_max, lat_min);
            if (rdy <= last_rdy) rdy = last_rdy + 1;
            last_rdy = rdy;
            if (mem_we_o) begin
                env_ram[mem_addr_o[6:2]] = merge(env_ram[mem_addr_o[6:2]], mem_wdata_o, mem_be_o);
                env_q.push_back('{rdy, 32'h0});
            end else begin
                env_q.push_back('{rdy, env_ram[mem_addr_o[6:2]]});
            end
        end
        if (instr_gnt_o) i_pend = 1'b0;
        if (data_gnt_o)  d_pend = 1'b0;
    endtask

    task automatic drain();
        gen_i   = 1'b0;
        gen_d   = 1'b0;
        gnt_pct = 100;
        for (int k = 0; k < 60 && (i_pend || d_pend || env_q.size() > 0); k++) cycle();
        chk("drain_done", {i_pend, d_pend, env_q.size() != 0}, 0);
    endtask

    always @(negedge clk) begin
        if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
            chk("mem_req", mem_req_o, cyc_q[0].req);
            chk("err", err_o, cyc_q[0].err);
            void'(cyc_q.pop_front());
        end
        if (instr_gnt_o && data_gnt_o) chk("dual_gnt", 1, 0);
        if ((gnt_q.size() > 0 && gnt_q[0].cyc == cyc) || instr_gnt_o || data_gnt_o) begin
            if (!(gnt_q.size() > 0 && gnt_q[0].cyc == cyc)) begin
                chk("unexpected_gnt", {instr_gnt_o, data_gnt_o}, 0);
            end else begin
                mg = gnt_q.pop_front();
                chk("gnt_instr", instr_gnt_o, !mg.id);
                chk("gnt_data", data_gnt_o, mg.id);
                chk("gnt_payload", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                    {mg.addr, mg.we, mg.be, mg.wdata});
            end
        end
        if (instr_rvalid_o && data_rvalid_o) chk("dual_rvalid", 1, 0);
        if ((rsp_q.size() > 0 && rsp_q[0].cyc == cyc) || instr_rvalid_o || data_rvalid_o) begin
            if (!(rsp_q.size() > 0 && rsp_q[0].cyc == cyc)) begin
                chk("unexpected_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
            end else begin
                mr = rsp_q.pop_front();
                chk("rvalid_instr", instr_rvalid_o, !mr.id);
                chk("rvalid_data", data_rvalid_o, mr.id);
                if (mr.rd) chk("rdata", mr.id ? data_rdata_o : instr_rdata_o, mr.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            env_ram[k] = 32'hA5000000 + 32'(k * 32'h1111);
            ref_ram[k] = env_ram[k];
        end
        @(posedge clk);
        #1;
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_gnt", {instr_gnt_o, data_gnt_o}, 0);
        chk("reset_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        chk("reset_err", err_o, 0);
        chk("reset_payload", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
        @(posedge clk);
        #2 rst_ni = 1'b1;

        // Instruction fetches 0x0, 0x4, 0x8 with single-cycle memory.
        for (int k = 0; k < 3; k++) begin
            i_pend = 1'b1;
            i_addr = 32'(k * 4);
            for (int t = 0; t < 10 && i_pend; t++) cycle();
        end
        drain();

        // Both requesters continuously: round-robin starting with DATA.
        gen_i = 1'b1;
        gen_d = 1'b1;
        req_pct = 100;
        for (int k = 0; k < 8; k++) cycle();
        drain();

        // Stalled store must hold the port while instr also requests.
        gnt_pct = 0;
        d_pend  = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                i_pend = 1'b1;
                i_addr = 32'h10;
            end
            cycle();
            chk("hold_payload", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                {32'h40, 1'b1, 4'b0011, 32'hDEADBEEF});
        end
        drain();

        // Slow memory: window fills, request re-presented after first rvalid.
        lat_min = 4;
        lat_max = 4;
        gen_i = 1'b1;
        gen_d = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        drain();

        // Random traffic.
        lat_min = 1;
        lat_max = 3;
        req_pct = 60;
        for (int k = 0; k < 400; k++) begin
            gen_i   = 1'b1;
            gen_d   = 1'b1;
            gnt_pct = 70;
            cycle();
        end
        drain();

        // Spurious rvalid sets a sticky error.
        spurious = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        // Reset with two transactions outstanding.
        lat_min = 6;
        lat_max = 6;
        req_pct = 100;
        gen_i = 1'b1;
        gen_d = 1'b1;
        for (int k = 0; k < 10 && m_q.size() < MAXO; k++) cycle();
        #3;
        rst_ni       = 1'b0;
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
        chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_count_flushed", mem_req_o, 1);
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        gen_i = 1'b0;
        gen_d = 1'b0;
        i_pend = 1'b0;
        d_pend = 1'b0;
        env_q.delete();
        m_q.delete();
        gnt_q.delete();
        rsp_q.delete();
        cyc_q.delete();
        m_hold_v = 1'b0;
        m_last   = 1'b0;
        m_err    = 1'b0;
        last_rdy = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_ni = 1'b1;

        // First tie after reset goes to DATA.
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 100;
        i_pend  = 1'b1;
        i_addr  = 32'h20;
        d_pend  = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h24;
        cycle();
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("leftover_expected", {gnt_q.size() != 0, rsp_q.size() != 0}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
